// File: rtl/keypad_input_pkg.sv
// Shared definitions for the keypad front end: input command codes,
// column priority encoder and counter sizing helper.
package keypad_input_pkg;

   // Command codes presented to the controller on in_cmd.
   localparam int IC_N = 5;
   localparam logic [IC_N-1:0] IC_NONE = 5'd0;
   localparam logic [IC_N-1:0] IC_NUM0 = 5'd1;
   localparam logic [IC_N-1:0] IC_NUM1 = 5'd2;
   localparam logic [IC_N-1:0] IC_NUM2 = 5'd3;
   localparam logic [IC_N-1:0] IC_NUM3 = 5'd4;
   localparam logic [IC_N-1:0] IC_NUM4 = 5'd5;
   localparam logic [IC_N-1:0] IC_NUM5 = 5'd6;
   localparam logic [IC_N-1:0] IC_NUM6 = 5'd7;
   localparam logic [IC_N-1:0] IC_NUM7 = 5'd8;
   localparam logic [IC_N-1:0] IC_NUM8 = 5'd9;
   localparam logic [IC_N-1:0] IC_NUM9 = 5'd10;
   localparam logic [IC_N-1:0] IC_EXDI = 5'd11;
   localparam logic [IC_N-1:0] IC_EXMU = 5'd12;
   localparam logic [IC_N-1:0] IC_EXSB = 5'd13;
   localparam logic [IC_N-1:0] IC_EXAD = 5'd14;
   localparam logic [IC_N-1:0] IC_EXOK = 5'd15;
   localparam logic [IC_N-1:0] IC_EXLP = 5'd16;
   localparam logic [IC_N-1:0] IC_EXRP = 5'd17;
   localparam logic [IC_N-1:0] IC_CLBK = 5'd18;
   localparam logic [IC_N-1:0] IC_CLCL = 5'd19;

   // Index of the lowest active-low column; callers only use it when one is low.
   function automatic logic [2:0] first_low(input logic [4:0] c);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 4; i >= 0; i--)
         if (!c[i]) idx = 3'(i);
      return idx;
   endfunction

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/keypad_input_map.sv
// Key matrix ROM: (row, column) of the latched key to its command code.
module keypad_input_map
   import keypad_input_pkg::*;
(
   input  logic [1:0]      row_i,
   input  logic [2:0]      col_i,
   output logic [IC_N-1:0] code_o
);

   // Spare key and column indices above 4 decode to no command.
   always_comb begin
      code_o = IC_NONE;
      case ({row_i, col_i})
         5'b00_000: code_o = IC_NUM7;
         5'b00_001: code_o = IC_NUM8;
         5'b00_010: code_o = IC_NUM9;
         5'b00_011: code_o = IC_EXDI;
         5'b00_100: code_o = IC_CLBK;
         5'b01_000: code_o = IC_NUM4;
         5'b01_001: code_o = IC_NUM5;
         5'b01_010: code_o = IC_NUM6;
         5'b01_011: code_o = IC_EXMU;
         5'b01_100: code_o = IC_CLCL;
         5'b10_000: code_o = IC_NUM1;
         5'b10_001: code_o = IC_NUM2;
         5'b10_010: code_o = IC_NUM3;
         5'b10_011: code_o = IC_EXSB;
         5'b10_100: code_o = IC_EXLP;
         5'b11_000: code_o = IC_NUM0;
         5'b11_010: code_o = IC_EXOK;
         5'b11_011: code_o = IC_EXAD;
         5'b11_100: code_o = IC_EXRP;
         default:   code_o = IC_NONE;
      endcase
   end

endmodule

// File: rtl/keypad_input.sv
// Keypad scanner: rotates a one-cold row drive over a 4x5 matrix, debounces
// one key at a time and holds its command code until acknowledged.
// Optional auto-repeat of the CLBK key is built when KEYPAD_REPEAT_EN is defined.
module keypad_input
   import keypad_input_pkg::*;
#(
   parameter int SCAN_DIV     = 256,
   parameter int DEBOUNCE     = 4096,
   parameter int REPEAT_DELAY = 2000000,
   parameter int REPEAT_RATE  = 500000
)(
   input  logic            Clock,
   input  logic            Reset,
   output logic [3:0]      row_n,
   input  logic [4:0]      col_n,
   output logic [IC_N-1:0] in_cmd,
   input  logic            in_ack
);

   // All counters share one width sized from the largest timing parameter.
   localparam int CNT_W = $clog2(max4(SCAN_DIV, DEBOUNCE, REPEAT_DELAY, REPEAT_RATE) + 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);
`endif

   typedef enum logic [2:0] {
      ST_SCAN,
      ST_DEBOUNCE,
      ST_PRESENT,
      ST_RELEASE
`ifdef KEYPAD_REPEAT_EN
      , ST_HOLD
`endif
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      row_q, row_d;
   logic [2:0]      col_q, col_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IC_N-1:0] cmd_q, cmd_d;
   logic [4:0]      col_m_q, col_s_q;
`ifdef KEYPAD_REPEAT_EN
   logic [CNT_W-1:0] rep_q, rep_d;
   logic             first_q, first_d;
`endif

   logic [IC_N-1:0] map_code;
   logic [7:0]      col_ext;
   logic            key_low;

   keypad_input_map u_map (
      .row_i  (row_q),
      .col_i  (col_q),
      .code_o (map_code)
   );

   // Padding keeps the latched-column select in range for any 3-bit index.
   assign col_ext = {3'b111, col_s_q};
   assign key_low = ~col_ext[col_q];
   assign row_n   = ~(4'b0001 << row_q);
   assign in_cmd  = cmd_q;

   // Two-flop synchroniser for the asynchronous column inputs.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         col_m_q <= '1;
         col_s_q <= '1;
      end else begin
         col_m_q <= col_n;
         col_s_q <= col_m_q;
      end
   end

   // State and datapath registers.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_SCAN;
         row_q   <= 2'd0;
         col_q   <= 3'd0;
         div_q   <= '0;
         cnt_q   <= '0;
         cmd_q   <= IC_NONE;
`ifdef KEYPAD_REPEAT_EN
         rep_q   <= '0;
         first_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         cmd_q   <= cmd_d;
`ifdef KEYPAD_REPEAT_EN
         rep_q   <= rep_d;
         first_q <= first_d;
`endif
      end
   end

   // Scan / debounce / present / release sequencing.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      div_d   = div_q;
      cnt_d   = cnt_q;
      cmd_d   = cmd_q;
`ifdef KEYPAD_REPEAT_EN
      rep_d   = rep_q;
      first_d = first_q;
`endif
      unique case (state_q)
         ST_SCAN: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (col_s_q != 5'h1f) begin
                  // Row stays frozen while the key is handled.
                  col_d   = first_low(col_s_q);
                  cnt_d   = '0;
                  state_d = ST_DEBOUNCE;
               end else begin
                  row_d = row_q + 2'd1;
               end
            end else begin
               div_d = div_q + ONE;
            end
         end
         ST_DEBOUNCE: begin
            if (key_low) begin
               if (cnt_q == DEB_LAST) begin
                  cnt_d = '0;
                  if (map_code == IC_NONE) begin
                     state_d = ST_RELEASE;
                  end else begin
                     cmd_d   = map_code;
                     state_d = ST_PRESENT;
`ifdef KEYPAD_REPEAT_EN
                     rep_d   = '0;
                     first_d = 1'b1;
`endif
                  end
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end else begin
               // Bounce: resume scanning from the following row.
               cnt_d   = '0;
               div_d   = '0;
               row_d   = row_q + 2'd1;
               state_d = ST_SCAN;
            end
         end
         ST_PRESENT: begin
`ifdef KEYPAD_REPEAT_EN
            if (rep_q != '1) rep_d = rep_q + ONE;
`endif
            if (in_ack) begin
               cmd_d   = IC_NONE;
               cnt_d   = '0;
               state_d = ST_RELEASE;
`ifdef KEYPAD_REPEAT_EN
               if (cmd_q == IC_CLBK) state_d = ST_HOLD;
               // After the first repeat the interval restarts at each ack.
               if (!first_q) rep_d = ONE;
`endif
            end
         end
         ST_RELEASE: begin
            if (!key_low) begin
               if (cnt_q == DEB_LAST) begin
                  cnt_d   = '0;
                  div_d   = '0;
                  row_d   = 2'd0;
                  state_d = ST_SCAN;
               end else begin
                  cnt_d = cnt_q + ONE;
               end
            end else begin
               cnt_d = '0;
            end
         end
`ifdef KEYPAD_REPEAT_EN
         ST_HOLD: begin
            if (!key_low) begin
               cnt_d   = '0;
               state_d = ST_RELEASE;
            end else if (rep_q >= (first_q ? DLY_LAST : RATE_LAST)) begin
               cmd_d   = IC_CLBK;
               first_d = 1'b0;
               state_d = ST_PRESENT;
            end else begin
               rep_d = rep_q + ONE;
            end
         end
`endif
         default: state_d = ST_SCAN;
      endcase
   end

endmodule

// File: tb/tb_keypad_input.sv
// Bench for keypad_input with a behavioural key matrix on row_n/col_n.
module tb_keypad_input;
   import keypad_input_pkg::*;

   logic            Clock = 1'b0;
   logic            Reset = 1'b1;
   logic            in_ack = 1'b0;
   logic [3:0]      row_n;
   logic [4:0]      col_n;
   logic [IC_N-1:0] in_cmd;
   logic [3:0][4:0] keys = '0;

   int checks = 0;
   int failures = 0;

   keypad_input #(
      .SCAN_DIV(4), .DEBOUNCE(8), .REPEAT_DELAY(64), .REPEAT_RATE(16)
   ) dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .row_n  (row_n),
      .col_n  (col_n),
      .in_cmd (in_cmd),
      .in_ack (in_ack)
   );

   always #5 Clock = ~Clock;

   // Pressed key pulls its column low only while its row is driven.
   always_comb begin
      col_n = 5'h1f;
      for (int r = 0; r < 4; r++)
         if (!row_n[r]) col_n = col_n & ~keys[r];
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic wait_code(input int bound);
      int w;
      w = 0;
      while (in_cmd == IC_NONE && w < bound) begin
         @(negedge Clock);
         w++;
      end
   endtask

   typedef struct {
      int              r;
      int              c;
      int              c2;
      int              ack_dly;
      logic [IC_N-1:0] exp;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic [3:0] exp_row;
      int n, seen, cnt;
      int t[3];
      logic [IC_N-1:0] prev;

      vecs[0] = '{2, 1, -1, 3, IC_NUM2};
      vecs[1] = '{0, 0,  3, 1, IC_NUM7};
      vecs[2] = '{1, 4, -1, 2, IC_CLCL};
      vecs[3] = '{3, 2, -1, 1, IC_EXOK};
      vecs[4] = '{2, 4, -1, 4, IC_EXLP};
      vecs[5] = '{0, 3, -1, 2, IC_EXDI};
      vecs[6] = '{3, 0, -1, 1, IC_NUM0};
      vecs[7] = '{1, 1, -1, 5, IC_NUM5};
      vecs[8] = '{3, 3, -1, 1, IC_EXAD};
      vecs[9] = '{1, 3, -1, 2, IC_EXMU};

      // Reset state and idle scan pattern.
      #1 Reset = 1'b0;
      repeat (3) @(negedge Clock);
      chk("reset_cmd", in_cmd, IC_NONE);
      chk("reset_row", row_n, 4'b1110);
      Reset = 1'b1;
      n = 0;
      for (int k = 0; k < 16; k++) begin
         exp_row = 4'hf & ~(4'b0001 << (k / 4));
         chk("scan_row", row_n, exp_row);
         if (in_cmd != IC_NONE) n++;
         @(negedge Clock);
      end
      chk("scan_idle_cmd", n, 0);

      // Table of single presses with varying ack delay.
      for (int i = 0; i < 10; i++) begin
         keys = '0;
         keys[vecs[i].r][vecs[i].c] = 1'b1;
         if (vecs[i].c2 >= 0) keys[vecs[i].r][vecs[i].c2] = 1'b1;
         wait_code(200);
         chk("code", in_cmd, vecs[i].exp);
         n = 0;
         for (int k = 1; k < vecs[i].ack_dly; k++) begin
            @(negedge Clock);
            if (in_cmd != vecs[i].exp) n++;
         end
         chk("held_until_ack", n, 0);
         in_ack = 1'b1;
         @(negedge Clock);
         in_ack = 1'b0;
         chk("cleared_after_ack", in_cmd, IC_NONE);
         n = 0;
         repeat (60) begin
            @(negedge Clock);
            if (in_cmd != IC_NONE) n++;
         end
         chk("single_code_while_held", n, 0);
         keys = '0;
         repeat (40) @(negedge Clock);
      end

      // Spare key produces nothing.
      keys[3][1] = 1'b1;
      n = 0;
      repeat (100) begin
         @(negedge Clock);
         if (in_cmd != IC_NONE) n++;
      end
      chk("spare_no_code", n, 0);
      keys = '0;
      repeat (40) @(negedge Clock);

      // Short press on r1c3 is rejected and scanning continues.
      keys[1][3] = 1'b1;
      n = 0;
      while (row_n != 4'b1101 && n < 50) begin
         @(negedge Clock);
         n++;
      end
      chk("short_reach_row1", row_n, 4'b1101);
      repeat (5) @(negedge Clock);
      keys = '0;
      n = 0;
      seen = 0;
      repeat (60) begin
         @(negedge Clock);
         if (in_cmd != IC_NONE) n++;
         if (row_n == 4'b0111) seen = 1;
      end
      chk("short_no_code", n, 0);
      chk("short_scan_resumes", seen, 1);

      // Long hold without ack, then asynchronous reset mid-present.
      keys[3][4] = 1'b1;
      wait_code(200);
      chk("hold_code", in_cmd, IC_EXRP);
      n = 0;
      repeat (1000) begin
         @(negedge Clock);
         if (in_cmd != IC_EXRP) n++;
      end
      chk("hold_1000", n, 0);
      #2 Reset = 1'b0;
      #1;
      chk("async_reset_cmd", in_cmd, IC_NONE);
      chk("async_reset_row", row_n, 4'b1110);
      @(negedge Clock);
      keys = '0;
      Reset = 1'b1;
      n = 0;
      repeat (40) begin
         @(negedge Clock);
         if (in_cmd != IC_NONE) n++;
      end
      chk("post_reset_idle", n, 0);

      // CLBK held with ack asserted every cycle.
      keys[0][4] = 1'b1;
      in_ack = 1'b1;
      cnt = 0;
      t[0] = 0; t[1] = 0; t[2] = 0;
      prev = IC_NONE;
      n = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge Clock);
         if (in_cmd == IC_CLBK && prev != IC_CLBK) begin
            if (cnt < 3) t[cnt] = k;
            cnt++;
         end
         if (in_cmd != IC_CLBK && in_cmd != IC_NONE) n++;
         prev = in_cmd;
      end
      chk("clbk_only_code", n, 0);
`ifdef KEYPAD_REPEAT_EN
      chk("repeat_count_ge3", (cnt >= 3) ? 1 : 0, 1);
      chk("repeat_delay_gap", (t[1] - t[0] >= 62 && t[1] - t[0] <= 66) ? 64 : t[1] - t[0], 64);
      chk("repeat_rate_gap", (t[2] - t[1] >= 14 && t[2] - t[1] <= 18) ? 16 : t[2] - t[1], 16);
`else
      chk("single_clbk", cnt, 1);
`endif
      in_ack = 1'b0;
      keys = '0;
      repeat (40) @(negedge Clock);
      chk("final_idle", in_cmd, IC_NONE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
